// File: rtl/ex_alu_branch_fwd.sv
// ---------------------------------------------------------------------------
// ex_alu_branch_fwd
//
// Execute stage of a five-stage RV32-style pipeline. It takes operands from
// the ID/EX stage and forwards results from the EX/MEM and MEM/WB stages onto
// them. It computes the ALU result and resolves branches and jumps. It then
// registers the values that the memory stage needs.
//
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   in_valid              : ID/EX instruction valid
//   pc, immediate         : instruction PC and sign-extended immediate
//   rs1_addr/rs2_addr     : source register indices
//   rs1_data/rs2_data     : register-file read data
//   rd_addr, reg_write    : destination index and write enable
//   funct3                : branch condition select
//   alu_op, alu_src       : ALU operation; alu_src=1 selects immediate as B
//   is_auipc/is_branch/is_jump/is_jalr : instruction class
//   ctrl_in               : opaque control bundle, carried to EX/MEM
//   mem_*                 : EX/MEM forwarding source
//   wb_*                  : MEM/WB forwarding source
//   branch_taken/target   : combinational redirect to fetch / hazard unit
//   alu_zero              : combinational, ALU result == 0
//   ex_mem_*              : registered EX/MEM pipeline outputs
//
// Handshake: none. The stage advances every cycle. in_valid qualifies the
// instruction, and ex_mem_valid is in_valid delayed by one cycle. Any
// stall or flush is applied upstream by driving in_valid low.
// ---------------------------------------------------------------------------
module ex_alu_branch_fwd #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   pc,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   immediate,
  input  logic [4:0]        rd_addr,
  input  logic [2:0]        funct3,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic              is_auipc,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              is_jalr,
  input  logic              reg_write,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [4:0]        mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   wb_write_data,
  input  logic [4:0]        wb_rd_addr,
  input  logic              wb_reg_write,
  output logic              branch_taken,
  output logic [XLEN-1:0]   branch_target,
  output logic              alu_zero,
  output logic              ex_mem_valid,
  output logic              ex_mem_reg_write,
  output logic [XLEN-1:0]   ex_mem_alu_result,
  output logic [XLEN-1:0]   ex_mem_rs2_data,
  output logic [4:0]        ex_mem_rd_addr,
  output logic [CTRL_W-1:0] ex_mem_ctrl
);

  // ALU operation encoding
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // Branch condition encoding (funct3)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic            w_br_eq;
  logic            w_br_lt_s;
  logic            w_br_lt_u;
  logic            w_cond_true;
  logic            w_taken_raw;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_target;

  logic              r_valid;
  logic              r_reg_write;
  logic [XLEN-1:0]   r_alu_result;
  logic [XLEN-1:0]   r_rs2_data;
  logic [4:0]        r_rd_addr;
  logic [CTRL_W-1:0] r_ctrl;

  // -------------------------------------------------------------------------
  // Operand forwarding. The EX/MEM stage holds the younger result, so it is
  // checked first. A destination of x0 never forwards, because x0 is
  // hard-wired to zero even when an instruction claims to write it.
  // -------------------------------------------------------------------------
  always_comb begin
    w_fwd_rs1 = rs1_data;
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs1_addr)) begin
      w_fwd_rs1 = mem_alu_result;
    end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr)) begin
      w_fwd_rs1 = wb_write_data;
    end
  end

  always_comb begin
    w_fwd_rs2 = rs2_data;
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs2_addr)) begin
      w_fwd_rs2 = mem_alu_result;
    end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr)) begin
      w_fwd_rs2 = wb_write_data;
    end
  end

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  assign w_alu_a = is_auipc ? pc : w_fwd_rs1;
  assign w_alu_b = alu_src ? immediate : w_fwd_rs2;
  assign w_shamt = w_alu_b[4:0];

  assign w_lt_signed   = $signed(w_alu_a) < $signed(w_alu_b);
  assign w_lt_unsigned = w_alu_a < w_alu_b;

  always_comb begin
    w_alu_result = '0;
    case (alu_op)
      ALU_ADD:  w_alu_result = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu_result = w_alu_a - w_alu_b;
      ALU_AND:  w_alu_result = w_alu_a & w_alu_b;
      ALU_OR:   w_alu_result = w_alu_a | w_alu_b;
      ALU_XOR:  w_alu_result = w_alu_a ^ w_alu_b;
      ALU_SLL:  w_alu_result = w_alu_a << w_shamt;
      ALU_SRL:  w_alu_result = w_alu_a >> w_shamt;
      ALU_SRA:  w_alu_result = $signed(w_alu_a) >>> w_shamt;
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      ALU_PASS: w_alu_result = w_alu_b;
      default:  w_alu_result = '0;
    endcase
  end

  assign alu_zero = (w_alu_result == '0);

  // -------------------------------------------------------------------------
  // Branch resolution. The comparator always uses the forwarded registers.
  // It never uses the ALU operands, because the ALU B input may hold the
  // immediate.
  // -------------------------------------------------------------------------
  assign w_br_eq   = (w_fwd_rs1 == w_fwd_rs2);
  assign w_br_lt_s = $signed(w_fwd_rs1) < $signed(w_fwd_rs2);
  assign w_br_lt_u = w_fwd_rs1 < w_fwd_rs2;

  always_comb begin
    w_cond_true = 1'b0;
    case (funct3)
      BR_EQ:   w_cond_true = w_br_eq;
      BR_NE:   w_cond_true = !w_br_eq;
      BR_LT:   w_cond_true = w_br_lt_s;
      BR_GE:   w_cond_true = !w_br_lt_s;
      BR_LTU:  w_cond_true = w_br_lt_u;
      BR_GEU:  w_cond_true = !w_br_lt_u;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_pc_target   = pc + immediate;
  assign w_jalr_sum    = w_fwd_rs1 + immediate;
  assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};

  // A jump is unconditional and takes precedence over the branch flag.
  assign w_taken_raw   = is_jump ? 1'b1 : (is_branch & w_cond_true);
  assign branch_taken  = in_valid & w_taken_raw;
  assign branch_target = (is_jump && is_jalr) ? w_jalr_target : w_pc_target;

  // -------------------------------------------------------------------------
  // EX/MEM pipeline register. The store data is always the forwarded rs2,
  // whatever alu_src selects.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_result <= '0;
      r_rs2_data   <= '0;
      r_rd_addr    <= '0;
      r_ctrl       <= '0;
    end else begin
      r_valid      <= in_valid;
      r_reg_write  <= reg_write & in_valid;
      r_alu_result <= w_alu_result;
      r_rs2_data   <= w_fwd_rs2;
      r_rd_addr    <= rd_addr;
      r_ctrl       <= ctrl_in;
    end
  end

  assign ex_mem_valid      = r_valid;
  assign ex_mem_reg_write  = r_reg_write;
  assign ex_mem_alu_result = r_alu_result;
  assign ex_mem_rs2_data   = r_rs2_data;
  assign ex_mem_rd_addr    = r_rd_addr;
  assign ex_mem_ctrl       = r_ctrl;

endmodule

// File: tb/tb_ex_alu_branch_fwd.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_branch_fwd
//
// Directed bench for ex_alu_branch_fwd. Every vector is driven just after
// a falling edge. The combinational branch and zero outputs are checked 1
// time unit later. If the vector will be captured, its expected EX/MEM
// record goes onto exp_q. The monitor samples 1 time unit after each rising
// edge. Whenever ex_mem_valid is high, it pops exp_q and compares the
// record.
// ---------------------------------------------------------------------------
module tb_ex_alu_branch_fwd;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int EXP_W  = 1 + XLEN + XLEN + 5 + CTRL_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [XLEN-1:0]   pc;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   immediate;
  logic [4:0]        rd_addr;
  logic [2:0]        funct3;
  logic [3:0]        alu_op;
  logic              alu_src;
  logic              is_auipc;
  logic              is_branch;
  logic              is_jump;
  logic              is_jalr;
  logic              reg_write;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0]   mem_alu_result;
  logic [4:0]        mem_rd_addr;
  logic              mem_reg_write;
  logic [XLEN-1:0]   wb_write_data;
  logic [4:0]        wb_rd_addr;
  logic              wb_reg_write;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic              alu_zero;
  logic              ex_mem_valid;
  logic              ex_mem_reg_write;
  logic [XLEN-1:0]   ex_mem_alu_result;
  logic [XLEN-1:0]   ex_mem_rs2_data;
  logic [4:0]        ex_mem_rd_addr;
  logic [CTRL_W-1:0] ex_mem_ctrl;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  ex_alu_branch_fwd #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .immediate(immediate), .rd_addr(rd_addr), .funct3(funct3),
    .alu_op(alu_op), .alu_src(alu_src), .is_auipc(is_auipc),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
    .reg_write(reg_write), .ctrl_in(ctrl_in),
    .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_write_data(wb_write_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .alu_zero(alu_zero), .ex_mem_valid(ex_mem_valid),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_rd_addr(ex_mem_rd_addr),
    .ex_mem_ctrl(ex_mem_ctrl)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_vec();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; pc = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
    immediate = '0; rd_addr = '0; funct3 = 3'b010; alu_op = 4'd0; alu_src = 1'b0;
    is_auipc = 1'b0; is_branch = 1'b0; is_jump = 1'b0; is_jalr = 1'b0;
    reg_write = 1'b0; ctrl_in = '0;
    mem_alu_result = '0; mem_rd_addr = '0; mem_reg_write = 1'b0;
    wb_write_data = '0; wb_rd_addr = '0; wb_reg_write = 1'b0;
  endtask

  // Check the combinational outputs, and queue the EX/MEM record when this
  // vector will be captured.
  task automatic issue(input string tag, input logic exp_taken, input logic [XLEN-1:0] exp_target,
                       input logic [XLEN-1:0] exp_alu, input logic [XLEN-1:0] exp_rs2);
    #1;
    chk({tag, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, exp_taken});
    chk({tag, ".branch_target"}, branch_target, exp_target);
    chk({tag, ".alu_zero"}, {31'd0, alu_zero}, {31'd0, (exp_alu == '0)});
    if (in_valid && !reset)
      exp_q.push_back({reg_write, exp_alu, exp_rs2, rd_addr, ctrl_in});
  endtask

  task automatic check_ex_mem_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, ex_mem_valid}, 32'd0);
    chk({tag, ".reg_write"}, {31'd0, ex_mem_reg_write}, 32'd0);
    chk({tag, ".alu_result"}, ex_mem_alu_result, 32'd0);
    chk({tag, ".rs2_data"}, ex_mem_rs2_data, 32'd0);
    chk({tag, ".rd_addr"}, {27'd0, ex_mem_rd_addr}, 32'd0);
    chk({tag, ".ctrl"}, {24'd0, ex_mem_ctrl}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] item;
    forever begin
      @(posedge clk);
      #1;
      if (ex_mem_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: ex_mem_valid=1 with no expected record (t=%0t)", $time);
        end else begin
          item = exp_q.pop_front();
          chk("ex_mem_reg_write", {31'd0, ex_mem_reg_write}, {31'd0, item[EXP_W-1]});
          chk("ex_mem_alu_result", ex_mem_alu_result, item[EXP_W-2 -: XLEN]);
          chk("ex_mem_rs2_data", ex_mem_rs2_data, item[5+CTRL_W+XLEN-1 -: XLEN]);
          chk("ex_mem_rd_addr", {27'd0, ex_mem_rd_addr}, {27'd0, item[CTRL_W+4 -: 5]});
          chk("ex_mem_ctrl", {24'd0, ex_mem_ctrl}, {24'd0, item[CTRL_W-1:0]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    new_vec();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_ex_mem_zero("reset_init");

    // Forwarding priority: both stages match rs1, so the MEM stage wins.
    new_vec();
    rs1_addr = 5'd5; rs1_data = 32'h33; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
    mem_alu_result = 32'h11; wb_rd_addr = 5'd5; wb_reg_write = 1'b1; wb_write_data = 32'h22;
    alu_src = 1'b1; pc = 32'h40; rs2_data = 32'h7; rd_addr = 5'd3; reg_write = 1'b1; ctrl_in = 8'hA5;
    issue("fwd_mem", 1'b0, 32'h40, 32'h11, 32'h7);

    // Same vector with MEM write disabled, so WB forwards.
    new_vec();
    rs1_addr = 5'd5; rs1_data = 32'h33; mem_rd_addr = 5'd5; mem_reg_write = 1'b0;
    mem_alu_result = 32'h11; wb_rd_addr = 5'd5; wb_reg_write = 1'b1; wb_write_data = 32'h22;
    alu_src = 1'b1; rd_addr = 5'd4; ctrl_in = 8'h3C;
    issue("fwd_wb", 1'b0, 32'h0, 32'h22, 32'h0);

    // WB forwards onto rs2: 0x10 + 0x1234.
    new_vec();
    rs1_addr = 5'd1; rs1_data = 32'h10; rs2_addr = 5'd7; rs2_data = 32'h9;
    wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_write_data = 32'h1234; reg_write = 1'b1; rd_addr = 5'd9;
    issue("fwd_wb_rs2", 1'b0, 32'h0, 32'h1244, 32'h1234);

    // x0 guard: a MEM write to x0 is not forwarded.
    new_vec();
    rs2_addr = 5'd0; mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_alu_result = 32'hFF;
    alu_op = 4'd10; reg_write = 1'b1; rd_addr = 5'd1;
    issue("x0_guard", 1'b0, 32'h0, 32'h0, 32'h0);

    // SLT with BLT, then SLTU with BLTU, on rs1=-1 and rs2=1.
    new_vec();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1;
    alu_op = 4'd8; is_branch = 1'b1; funct3 = 3'b100; pc = 32'h200; immediate = 32'h10; ctrl_in = 8'h01;
    issue("slt_blt", 1'b1, 32'h210, 32'h1, 32'h1);
    new_vec();
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1;
    alu_op = 4'd9; is_branch = 1'b1; funct3 = 3'b110; pc = 32'h200; immediate = 32'h10; ctrl_in = 8'h02;
    issue("sltu_bltu", 1'b0, 32'h210, 32'h0, 32'h1);

    // BGE signed not taken, then BGEU taken.
    new_vec();
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1; is_branch = 1'b1; funct3 = 3'b101;
    pc = 32'h80; immediate = 32'h8; alu_op = 4'd4;
    issue("bge", 1'b0, 32'h88, 32'hFFFF_FFFE, 32'h1);
    new_vec();
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1; is_branch = 1'b1; funct3 = 3'b111;
    pc = 32'h80; immediate = 32'h8; alu_op = 4'd3;
    issue("bgeu", 1'b1, 32'h88, 32'hFFFF_FFFF, 32'h1);

    // BEQ on a MEM-forwarded rs1 is taken; XOR of equal values gives zero.
    new_vec();
    rs1_addr = 5'd3; rs1_data = 32'h5; mem_rd_addr = 5'd3; mem_reg_write = 1'b1; mem_alu_result = 32'h9;
    rs2_addr = 5'd4; rs2_data = 32'h9; is_branch = 1'b1; funct3 = 3'b000; alu_op = 4'd4;
    pc = 32'h1000; immediate = 32'hFFFF_FFFC;
    issue("beq_fwd", 1'b1, 32'h0FFC, 32'h0, 32'h9);

    // SUB wraps, BNE taken; funct3 010 is never taken.
    new_vec();
    rs1_data = 32'h5; rs2_data = 32'h7; alu_op = 4'd1; is_branch = 1'b1; funct3 = 3'b001;
    pc = 32'h20; immediate = 32'h20; reg_write = 1'b1; rd_addr = 5'd31;
    issue("sub_bne", 1'b1, 32'h40, 32'hFFFF_FFFE, 32'h7);
    new_vec();
    rs1_data = 32'h5; rs2_data = 32'h7; is_branch = 1'b1; funct3 = 3'b010; alu_op = 4'd12;
    pc = 32'h20; immediate = 32'h20;
    issue("br_010", 1'b0, 32'h40, 32'h0, 32'h7);

    // JALR clears bit 0 of the target; with in_valid low it is not taken.
    new_vec();
    rs1_data = 32'h1001; immediate = 32'h4; alu_src = 1'b1; is_jump = 1'b1; is_jalr = 1'b1;
    pc = 32'h300; reg_write = 1'b1; rd_addr = 5'd1;
    issue("jalr", 1'b1, 32'h1004, 32'h1005, 32'h0);
    new_vec();
    in_valid = 1'b0;
    rs1_data = 32'h1001; immediate = 32'h4; alu_src = 1'b1; is_jump = 1'b1; is_jalr = 1'b1;
    pc = 32'h300; reg_write = 1'b1; rd_addr = 5'd1;
    issue("jalr_invalid", 1'b0, 32'h1004, 32'h1005, 32'h0);

    // JAL overrides a never-taken branch, with a negative offset.
    new_vec();
    is_jump = 1'b1; is_branch = 1'b1; funct3 = 3'b010; pc = 32'h400; immediate = 32'hFFFF_FFF0;
    alu_op = 4'd10; alu_src = 1'b1;
    issue("jal", 1'b1, 32'h3F0, 32'hFFFF_FFF0, 32'h0);

    // AUIPC, then the shifts.
    new_vec();
    pc = 32'h100; immediate = 32'h2000; is_auipc = 1'b1; alu_src = 1'b1; rs1_data = 32'hDEAD;
    issue("auipc", 1'b0, 32'h2100, 32'h2100, 32'h0);
    new_vec();
    rs1_data = 32'h8000_0000; immediate = 32'h4; alu_src = 1'b1; alu_op = 4'd7;
    issue("sra", 1'b0, 32'h4, 32'hF800_0000, 32'h0);
    new_vec();
    rs1_data = 32'h8000_0000; immediate = 32'h4; alu_src = 1'b1; alu_op = 4'd6;
    issue("srl", 1'b0, 32'h4, 32'h0800_0000, 32'h0);
    new_vec();
    rs1_data = 32'h1; rs2_data = 32'h3F; alu_op = 4'd5;
    issue("sll", 1'b0, 32'h0, 32'h8000_0000, 32'h3F);
    new_vec();
    rs1_data = 32'hF0F0; rs2_data = 32'h0FF0; alu_op = 4'd2; reg_write = 1'b1;
    issue("and", 1'b0, 32'h0, 32'h00F0, 32'h0FF0);

    // Mid-stream reset: a captured instruction is followed by one reset
    // cycle that carries a valid instruction. The branch output is still live.
    new_vec();
    rs1_data = 32'h77; alu_op = 4'd3; reg_write = 1'b1; rd_addr = 5'd12; ctrl_in = 8'hFF;
    issue("pre_reset", 1'b0, 32'h0, 32'h77, 32'h0);
    new_vec();
    reset = 1'b1;
    rs1_data = 32'h55; alu_op = 4'd3; reg_write = 1'b1; rd_addr = 5'd13; ctrl_in = 8'hEE;
    is_jump = 1'b1; pc = 32'h10; immediate = 32'h10;
    issue("in_reset", 1'b1, 32'h20, 32'h55, 32'h0);
    @(negedge clk);
    check_ex_mem_zero("reset_mid");

    new_vec();
    in_valid = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_branch_fwd.md
EX_ALU_BRANCH_FWD -- requirements
Module: ex_alu_branch_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter CTRL_W, default 8, width of pass-through control bundle.
REQ-003 Ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  ID/EX instruction valid.
- pc  in  XLEN  instruction PC.
- rs1_addr, rs2_addr  in  5  source register indices.
- rs1_data, rs2_data  in  XLEN  register-file read data.
- immediate  in  XLEN  sign-extended immediate.
- rd_addr  in  5  destination index.
- funct3  in  3  branch condition.
- alu_op  in  4  ALU operation.
- alu_src  in  1  1 = ALU B is immediate.
- is_auipc, is_branch, is_jump, is_jalr  in  1 each  instruction class.
- reg_write  in  1  instruction writes rd.
- ctrl_in  in  CTRL_W  opaque control, passed through.
- mem_alu_result  in  XLEN; mem_rd_addr  in  5; mem_reg_write  in  1  EX/MEM forwarding source.
- wb_write_data  in  XLEN; wb_rd_addr  in  5; wb_reg_write  in  1  MEM/WB forwarding source.
- branch_taken  out  1; branch_target  out  XLEN  redirect to fetch/hazard unit, combinational.
- alu_zero  out  1  combinational, ALU result == 0.
- ex_mem_valid, ex_mem_reg_write  out  1; ex_mem_alu_result, ex_mem_rs2_data  out  XLEN; ex_mem_rd_addr  out  5; ex_mem_ctrl  out  CTRL_W  registered EX/MEM.

Function
REQ-004 Forward A: if mem_reg_write and mem_rd_addr!=0 and mem_rd_addr==rs1_addr, use mem_alu_result. Else, if wb_reg_write and wb_rd_addr!=0 and wb_rd_addr==rs1_addr, use wb_write_data. Else use rs1_data. MEM has priority when both match.
REQ-005 Forward B: identical rule on rs2_addr/rs2_data.
REQ-006 ALU A = pc if is_auipc, else forwarded rs1. ALU B = immediate if alu_src, else forwarded rs2.
REQ-007 alu_op encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 SRA; shift amount B[4:0].
- 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
- 10 PASS_B.
- 11-15 result 0.
REQ-008 Arithmetic wraps modulo 2^XLEN; no overflow flag.
REQ-009 Branch compare uses forwarded rs1/rs2. funct3 conditions:
- 000 EQ, 001 NE.
- 100 LT signed, 101 GE signed.
- 110 LT unsigned, 111 GE unsigned.
- 010/011 never taken.
REQ-010 Jumps: is_jump and not is_jalr (JAL) is always taken, target pc+immediate. is_jump and is_jalr (JALR) is always taken, target (forwarded rs1 + immediate) with bit0 cleared. is_jump overrides is_branch.
REQ-011 Conditional branch target = pc+immediate. With no branch/jump, branch_taken=0 and branch_target=pc+immediate.
REQ-012 branch_taken SHALL be 0 whenever in_valid=0.
REQ-013 Each rising clk, EX/MEM registers capture:
- ex_mem_alu_result = ALU result.
- ex_mem_rs2_data = forwarded rs2 (store data, independent of alu_src).
- ex_mem_rd_addr = rd_addr; ex_mem_ctrl = ctrl_in.
- ex_mem_reg_write = reg_write & in_valid; ex_mem_valid = in_valid.
REQ-014 Latency: branch outputs and alu_zero are 0-cycle; EX/MEM outputs are 1-cycle.

Reset
REQ-015 While reset is high at a rising clk, every EX/MEM output SHALL become 0. Reset SHALL override capture, including mid-stream.
REQ-016 Combinational outputs SHALL not depend on reset.

Verification
REQ-017 Forwarding priority: rs1_addr=5, mem_rd=5/mem_we=1/mem_res=0x11, wb_rd=5/wb_we=1/wb_data=0x22, rs1_data=0x33, ADD alu_src=1 imm=0 -> ex_mem_alu_result=0x11 next cycle. With mem_we=0 -> 0x22.
REQ-018 x0 guard: rs2_addr=0, mem_rd=0, mem_we=1, mem_res=0xFF, rs2_data=0 -> ex_mem_rs2_data=0.
REQ-019 Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1. SLT -> 1, SLTU -> 0. BLT (100) taken, BLTU (110) not taken.
REQ-020 JALR: rs1=0x1001, imm=4, in_valid=1 -> branch_taken=1, target=0x1004. Same with in_valid=0 -> branch_taken=0.
REQ-021 AUIPC/SRA: pc=0x100, imm=0x2000, is_auipc, ADD -> 0x2100. SRA of 0x80000000 by 4 -> 0xF8000000.
REQ-022 Reset: valid instruction captured, then reset=1 for one cycle -> ex_mem_valid, ex_mem_reg_write and all data outputs 0.
